// File: rtl/psone_frame_tx_if.sv
// Pad-packet input and UART byte-stream output of the frame transmitter.
interface psone_frame_tx_if;
  logic       iBYTE_VLD;
  logic [7:0] iBYTE;
  logic       iPKT_END;
  logic       oTX_ST;
  logic [7:0] oTX_BYTE;
  logic       iTX_BUSY;
  logic       oBUSY;
  logic [7:0] oDROP_CNT;
  logic [7:0] oERR_CNT;

  modport slave (
    input  iBYTE_VLD, iBYTE, iPKT_END, iTX_BUSY,
    output oTX_ST, oTX_BYTE, oBUSY, oDROP_CNT, oERR_CNT
  );

  modport master (
    output iBYTE_VLD, iBYTE, iPKT_END, iTX_BUSY,
    input  oTX_ST, oTX_BYTE, oBUSY, oDROP_CNT, oERR_CNT
  );
endinterface

// File: rtl/psone_frame_tx.sv
// Ping-pong buffered framer: pad packet in, HDR/LEN/payload/XOR frame out to UART.
module psone_frame_tx #(
  parameter int unsigned PKT_LEN = 9,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input logic             iCLK,
  input logic             iRESET,
  psone_frame_tx_if.slave bus
);
  localparam logic [3:0] LEN4 = 4'(PKT_LEN);
  localparam logic [7:0] LEN8 = 8'(PKT_LEN);
  localparam logic [4:0] LAST = 5'(PKT_LEN + 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_mem [2][PKT_LEN];
  logic [1:0] r_full;
  logic       r_wr_bank, r_rd_bank;
  logic [3:0] r_wr_cnt;
  logic       r_drop, r_ovf;
  logic [7:0] r_drop_cnt, r_err_cnt;
  logic [4:0] r_idx;
  logic [7:0] r_chk;
  logic       r_tx_st;
  logic [7:0] r_tx_byte;

  logic       w_full_wr, w_store, w_drop_eff, w_ovf_eff;
  logic [3:0] w_cnt_eff;
  logic       w_commit, w_drop_evt, w_err_evt;
  logic       w_release, w_chk_en;
  logic [7:0] w_byte;
  logic [3:0] w_pidx;

  // Effective packet status including a byte arriving in the same cycle as the end strobe.
  always_comb begin
    w_full_wr  = r_full[r_wr_bank];
    w_store    = bus.iBYTE_VLD && !w_full_wr && (r_wr_cnt < LEN4);
    w_cnt_eff  = r_wr_cnt + {3'b000, w_store};
    w_drop_eff = r_drop || (bus.iBYTE_VLD && w_full_wr);
    w_ovf_eff  = r_ovf || (bus.iBYTE_VLD && !w_full_wr && (r_wr_cnt >= LEN4));
    w_drop_evt = bus.iPKT_END && w_drop_eff;
    w_err_evt  = bus.iPKT_END && !w_drop_eff && (w_ovf_eff || (w_cnt_eff != LEN4));
    w_commit   = bus.iPKT_END && !w_drop_eff && !w_ovf_eff && (w_cnt_eff == LEN4);
  end

  // Payload storage; contents are don't-care until the bank is marked full.
  always_ff @(posedge iCLK) begin
    if (w_store) r_mem[r_wr_bank][r_wr_cnt] <= bus.iBYTE;
  end

  // Write pointer, byte count, per-packet flags and saturating event counters.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_drop     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (bus.iPKT_END) begin
      r_wr_cnt <= '0;
      r_drop   <= 1'b0;
      r_ovf    <= 1'b0;
      if (w_commit) r_wr_bank <= ~r_wr_bank;
      if (w_drop_evt && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_err_evt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_wr_cnt <= w_cnt_eff;
      r_drop   <= w_drop_eff;
      r_ovf    <= w_ovf_eff;
    end
  end

  // Bank-full flags: commit and release hit different banks and may coincide.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_full <= '0;
    end else begin
      r_full <= (r_full | ({1'b0, w_commit} << r_wr_bank)) & ~({1'b0, w_release} << r_rd_bank);
    end
  end

  // TX FSM state register.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // TX FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (r_full[r_rd_bank]) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_START;
      S_START:   w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (bus.iTX_BUSY) w_state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (!bus.iTX_BUSY) w_state_nxt = (r_idx < LAST) ? S_LOAD : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // TX output decode: frame byte selection, checksum enable and bank release.
  always_comb begin
    w_pidx    = 4'(r_idx - 5'd2);
    w_byte    = r_chk;
    w_chk_en  = 1'b0;
    w_release = (r_state == S_WAIT_LO) && !bus.iTX_BUSY && (r_idx == LAST);
    if (r_idx == 5'd0) begin
      w_byte = HDR;
    end else if (r_idx == 5'd1) begin
      w_byte   = LEN8;
      w_chk_en = 1'b1;
    end else if (r_idx != LAST) begin
      w_byte   = r_mem[r_rd_bank][w_pidx];
      w_chk_en = 1'b1;
    end
  end

  // TX registered outputs, frame index, checksum accumulator and read pointer.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_idx     <= '0;
      r_chk     <= '0;
      r_tx_st   <= 1'b0;
      r_tx_byte <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          r_chk <= '0;
        end
        S_LOAD: begin
          r_tx_byte <= w_byte;
          r_tx_st   <= 1'b1;
          if (w_chk_en) r_chk <= r_chk ^ w_byte;
        end
        S_START: r_tx_st <= 1'b0;
        S_WAIT_LO: begin
          if (!bus.iTX_BUSY) begin
            if (r_idx < LAST) begin
              r_idx <= r_idx + 5'd1;
            end else begin
              r_idx     <= '0;
              r_rd_bank <= ~r_rd_bank;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oTX_ST    = r_tx_st;
  assign bus.oTX_BYTE  = r_tx_byte;
  assign bus.oBUSY     = (r_state != S_IDLE);
  assign bus.oDROP_CNT = r_drop_cnt;
  assign bus.oERR_CNT  = r_err_cnt;
endmodule

// File: doc/psone_frame_tx.md
# psone_frame_tx

Packet framer between the PlayStation pad SPI poller and the byte-level UART transmitter. It collects one polled pad packet (PKT_LEN bytes) into a two-bank ping-pong buffer. It then emits it to the UART as a framed message: header, length, payload, XOR checksum. This decouples SPI polling from UART pacing, so a new poll can be captured while the previous frame is still being sent.

## Interface
- PKT_LEN, 9, payload bytes per pad packet; legal range 1..15
- HDR, 8'hA5, frame sync byte sent first
- iCLK  in  1  system clock
- iRESET  in  1  reset; one clock; reset is asynchronous and active-low
- iBYTE_VLD  in  1  one-cycle strobe: iBYTE holds a received pad byte
- iBYTE  in  8  pad byte from SPI poller
- iPKT_END  in  1  one-cycle strobe: packet complete (same cycle as, or after, the last iBYTE_VLD)
- oTX_ST  out  1  one-cycle request to UART to send oTX_BYTE
- oTX_BYTE  out  8  byte to UART
- iTX_BUSY  in  1  UART transmit busy (high while shifting)
- oBUSY  out  1  high while a frame is being transmitted
- oDROP_CNT  out  8  saturating count of packets dropped (no free bank)
- oERR_CNT  out  8  saturating count of packets discarded for length mismatch

## Operation
- Storage: 2 banks × PKT_LEN × 8 bit. Flags full[1:0], pointers wr_bank, rd_bank, 4-bit wr_cnt, per-packet drop flag.
- Write side:
  - iBYTE_VLD with full[wr_bank]=0 and wr_cnt<PKT_LEN: store at [wr_bank][wr_cnt], then wr_cnt+1.
  - iBYTE_VLD with wr_cnt≥PKT_LEN: byte ignored; the length mismatch is flagged at end.
  - iBYTE_VLD with full[wr_bank]=1: byte ignored; drop flag set.
- iPKT_END, evaluated in this priority order:
  - drop flag set: oDROP_CNT+1 (saturate at 255).
  - else wr_cnt≠PKT_LEN (includes overflow): oERR_CNT+1 (saturate).
  - else: full[wr_bank]<=1 and wr_bank toggles.
  - In all cases wr_cnt<=0 and the drop flag clears.
- iBYTE_VLD and iPKT_END in the same cycle: the byte is stored first, and the end check counts it.
- Frame order, by index i:
  - i=0: HDR
  - i=1: PKT_LEN
  - i=2..PKT_LEN+1: payload, byte 0 first
  - i=PKT_LEN+2: checksum
- Checksum = XOR of the length byte and all payload bytes. HDR is excluded.
- TX FSM:
  - IDLE: full[rd_bank]=1 → LOAD.
  - LOAD: oTX_BYTE <= byte(i), oTX_ST <= 1 → START.
  - START: oTX_ST <= 0 → WAIT_HI.
  - WAIT_HI: iTX_BUSY=1 → WAIT_LO.
  - WAIT_LO: on iTX_BUSY falling:
    - i<PKT_LEN+2: i+1 → LOAD.
    - else: full[rd_bank] <= 0, rd_bank toggles, i <= 0 → IDLE.
- Checksum accumulator clears in IDLE and XORs each byte with i≥1 as it is loaded.
- oBUSY = (state≠IDLE).
- A commit on the write side and a release on the read side in the same cycle are legal. They always target different banks, and both flags update.
- Reset mid-frame: all state is cleared, buffered packets are lost, and the FSM restarts in IDLE. There is no partial-frame resume.

## Timing
- Reset values: oTX_ST=0, oTX_BYTE=8'h00, oBUSY=0, oDROP_CNT=0, oERR_CNT=0, full=2'b00, wr_bank=rd_bank=0, state IDLE.
- iPKT_END sampled at edge N (valid packet, FSM idle): full set at N, LOAD at N+1, oTX_ST high from N+2 to N+3 with oTX_BYTE=HDR.
- oTX_ST width is exactly 1 cycle.
- oTX_BYTE holds stable from oTX_ST rise until the iTX_BUSY fall for that byte.
- Inter-byte gap: next oTX_ST rises 2 cycles after the cycle iTX_BUSY is first sampled low in WAIT_LO.
- Frame length = PKT_LEN+3 UART bytes.
- Back-to-back: a second committed bank starts at LOAD one cycle after IDLE is re-entered.
- All outputs are registered. No combinational path from iBYTE or iTX_BUSY to outputs.

## Test plan
- Nominal frame: send PKT_LEN=9 bytes 00,41,5A,FF,FF,80,80,80,80, then iPKT_END; UART model busy 20 cycles per byte → exactly 12 oTX_ST pulses with bytes A5,09,00,41,5A,FF,FF,80,80,80,80,12; oBUSY falls after the last busy fall.
- Ping-pong: commit packet A; commit packet B during A's transmission; start packet C while both banks are full → A then B framed back-to-back; C dropped with oDROP_CNT=1 and oERR_CNT=0.
- Length errors: 8 bytes + iPKT_END, then 11 bytes + iPKT_END → oERR_CNT=2, no oTX_ST, full stays 00.
- Last iBYTE_VLD and iPKT_END in the same cycle → packet committed; frame correct.
- Assert iRESET low during the 5th byte's WAIT_LO → all outputs at reset values immediately. After release with no new input, no oTX_ST is issued.
- Counter saturation: 260 drop events → oDROP_CNT=255.
